// File: rtl/gf_serial_pkg.sv
// Shared definitions for the GF multiplier serial link: host FSM state
// encoding and the bit order used by both ends of the link.
package gf_serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } gf_state_e;

    // Operands and product travel most-significant bit first.
    localparam bit MSB_FIRST = 1'b1;

    function automatic int cnt_width(input int data_width);
        return $clog2(2 * data_width + 1);
    endfunction

endpackage

// File: rtl/gf_serial_if.sv
// Bundle of the CPU-side request/result signals and the serial link lines
// between the host and a serial-wrapped multiplier.
interface gf_serial_if #(
    parameter int DATA_WIDTH = 8
);
    // Handshake: start is sampled only while the host is idle (busy=0 and
    // done=0); op_a/op_b must be valid in that same cycle. done pulses for one
    // cycle with result valid, and result holds until the next done or reset.
    logic                        start;
    logic [DATA_WIDTH-1:0]       op_a;
    logic [DATA_WIDTH-1:0]       op_b;
    logic                        busy;
    logic                        done;
    logic [2*DATA_WIDTH-1:0]     result;

    logic                        ser_a;
    logic                        ser_b;
    logic                        ser_en;
    logic                        par_load;
    logic                        ser_result;

    modport master (
        output start, op_a, op_b, ser_result,
        input  busy, done, result, ser_a, ser_b, ser_en, par_load
    );

    modport slave (
        input  start, op_a, op_b, ser_result,
        output busy, done, result, ser_a, ser_b, ser_en, par_load
    );

endinterface

// File: rtl/gf_shift_reg.sv
// Loadable shift register with serial and parallel taps; load wins over shift.
// Serial output comes straight from a flop so it is glitch-free on the link.
module gf_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] par_in_i,
    input  logic             shift_i,
    input  logic             ser_in_i,
    output logic             ser_out_o,
    output logic [WIDTH-1:0] par_out_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = par_in_i;
        end else if (shift_i) begin
            data_d = MSB_FIRST ? {data_q[WIDTH-2:0], ser_in_i}
                               : {ser_in_i, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign ser_out_o = MSB_FIRST ? data_q[WIDTH-1] : data_q[0];
    assign par_out_o = data_q;

endmodule

// File: rtl/gf_serial_host.sv
// Host end of the GF multiplier serial link: shifts two operands out, pulses
// the remote compute/load controls, then collects the serial product.
module gf_serial_host
    import gf_serial_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int COMPUTE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    gf_serial_if.slave      bus,
    output gf_state_e       state_o
);

    localparam int DW    = DATA_WIDTH;
    localparam int RW    = 2 * DATA_WIDTH;
    localparam int CNT_W = cnt_width(DATA_WIDTH);

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(DW - 1);
    localparam logic [CNT_W-1:0] COMP_LAST  = CNT_W'(COMPUTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(RW - 1);

    gf_state_e        state_q;
    gf_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             load_ops;
    logic             shift_ops;
    logic             shift_cap;

    logic             ser_en_q;
    logic             par_load_q;
    logic             busy_q;
    logic             done_q;
    logic [RW-1:0]    result_q;

    logic             a_ser;
    logic             b_ser;
    logic [DW-1:0]    a_par;
    logic [DW-1:0]    b_par;
    logic             cap_ser;
    logic [RW-1:0]    cap_par;
    logic             unused_taps;

    // Operand shifters fill with zeros, so once all bits are out the serial
    // lines sit at 0 for COMPUTE and beyond without extra gating.
    gf_shift_reg #(.WIDTH(DW), .MSB_FIRST(MSB_FIRST)) u_shift_a (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load_ops),
        .par_in_i  (bus.op_a),
        .shift_i   (shift_ops),
        .ser_in_i  (1'b0),
        .ser_out_o (a_ser),
        .par_out_o (a_par)
    );

    gf_shift_reg #(.WIDTH(DW), .MSB_FIRST(MSB_FIRST)) u_shift_b (
        .clk       (clk),
        .reset     (reset),
        .load_i    (load_ops),
        .par_in_i  (bus.op_b),
        .shift_i   (shift_ops),
        .ser_in_i  (1'b0),
        .ser_out_o (b_ser),
        .par_out_o (b_par)
    );

    gf_shift_reg #(.WIDTH(RW), .MSB_FIRST(MSB_FIRST)) u_capture (
        .clk       (clk),
        .reset     (reset),
        .load_i    (1'b0),
        .par_in_i  ('0),
        .shift_i   (shift_cap),
        .ser_in_i  (bus.ser_result),
        .ser_out_o (cap_ser),
        .par_out_o (cap_par)
    );

    assign unused_taps = ^{a_par, b_par, cap_ser};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_ops  = 1'b0;
        shift_ops = 1'b0;
        shift_cap = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    load_ops = 1'b1;
                    state_d  = ST_SHIFT;
                    cnt_d    = '0;
                end
            end
            ST_SHIFT: begin
                shift_ops = 1'b1;
                if (cnt_q == SHIFT_LAST) begin
                    state_d = ST_COMPUTE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_COMPUTE: begin
                if (cnt_q == COMP_LAST) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                shift_cap = 1'b1;
                if (cnt_q == CAP_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ser_en_q   <= 1'b0;
            par_load_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ser_en_q   <= (state_d == ST_COMPUTE);
            par_load_q <= (state_d == ST_COMPUTE) && (cnt_d == COMP_LAST);
            busy_q     <= (state_d == ST_SHIFT) || (state_d == ST_COMPUTE) ||
                          (state_d == ST_CAPTURE);
            done_q     <= (state_d == ST_DONE);
            if ((state_q == ST_CAPTURE) && (state_d == ST_DONE)) begin
                result_q <= {cap_par[RW-2:0], bus.ser_result};
            end
        end
    end

    assign bus.ser_a    = a_ser;
    assign bus.ser_b    = b_ser;
    assign bus.ser_en   = ser_en_q;
    assign bus.par_load = par_load_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_gf_serial_host.sv
// Bench for gf_serial_host at 8/2 and 4/1 with a remote multiplier model
// (serial-in operand regs, carry-less multiply, PISO product register).
module tb_gf_serial_host;
    import gf_serial_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gf_serial_if #(.DATA_WIDTH(8)) bus0 ();
    gf_serial_if #(.DATA_WIDTH(4)) bus1 ();
    gf_state_e st0;
    gf_state_e st1;

    gf_serial_host #(.DATA_WIDTH(8), .COMPUTE_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .state_o(st0)
    );
    gf_serial_host #(.DATA_WIDTH(4), .COMPUTE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .state_o(st1)
    );

    function automatic logic [15:0] clmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ ({8'h00, a} << i);
        end
        return r;
    endfunction

    // Remote side models: operand regs freeze while ser_en is high.
    logic [7:0]  a0_rem = '0, b0_rem = '0;
    logic [15:0] piso0  = '0;
    logic [3:0]  a1_rem = '0, b1_rem = '0;
    logic [7:0]  piso1  = '0;
    logic [15:0] prod1;

    assign prod1 = clmul({4'h0, a1_rem}, {4'h0, b1_rem});
    assign bus0.ser_result = piso0[15];
    assign bus1.ser_result = piso1[7];

    always @(posedge clk) begin
        if (!bus0.ser_en) begin
            a0_rem <= {a0_rem[6:0], bus0.ser_a};
            b0_rem <= {b0_rem[6:0], bus0.ser_b};
        end
        if (bus0.par_load) piso0 <= clmul(a0_rem, b0_rem);
        else piso0 <= {piso0[14:0], 1'b0};
        if (!bus1.ser_en) begin
            a1_rem <= {a1_rem[2:0], bus1.ser_a};
            b1_rem <= {b1_rem[2:0], bus1.ser_b};
        end
        if (bus1.par_load) piso1 <= prod1[7:0];
        else piso1 <= {piso1[6:0], 1'b0};
    end

    logic [15:0] exp0_q[$];
    int          exp0_cyc_q[$];
    logic [7:0]  exp1_q[$];
    int          exp1_cyc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever a done pulse appears.
    always @(negedge clk) begin
        if (bus0.done) begin
            if (exp0_q.size() == 0) begin
                chk("unexpected_done0", 32'(bus0.result), 32'hFFFF_FFFF);
            end else begin
                chk("result0", 32'(bus0.result), 32'(exp0_q.pop_front()));
                chk("latency0", 32'(cyc), 32'(exp0_cyc_q.pop_front()));
                chk("busy_at_done0", 32'(bus0.busy), 32'd0);
            end
        end
        if (bus1.done) begin
            if (exp1_q.size() == 0) begin
                chk("unexpected_done1", 32'(bus1.result), 32'hFFFF_FFFF);
            end else begin
                chk("result1", 32'(bus1.result), 32'(exp1_q.pop_front()));
                chk("latency1", 32'(cyc), 32'(exp1_cyc_q.pop_front()));
            end
        end
    end

    task automatic wait_idle0();
        int n = 0;
        while ((st0 != ST_IDLE || bus0.done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle0_timeout", 32'(n), 32'd0);
    endtask

    task automatic wait_idle1();
        int n = 0;
        while ((st1 != ST_IDLE || bus1.done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle1_timeout", 32'(n), 32'd0);
    endtask

    task automatic send0(input logic [7:0] a, input logic [7:0] b);
        wait_idle0();
        bus0.start = 1'b1;
        bus0.op_a  = a;
        bus0.op_b  = b;
        exp0_q.push_back(clmul(a, b));
        exp0_cyc_q.push_back(cyc + 27);
        @(negedge clk);
        bus0.start = 1'b0;
    endtask

    task automatic send1(input logic [3:0] a, input logic [3:0] b);
        logic [15:0] p;
        wait_idle1();
        p = clmul({4'h0, a}, {4'h0, b});
        bus1.start = 1'b1;
        bus1.op_a  = a;
        bus1.op_b  = b;
        exp1_q.push_back(p[7:0]);
        exp1_cyc_q.push_back(cyc + 14);
        @(negedge clk);
        bus1.start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.start = 1'b0; bus0.op_a = '0; bus0.op_b = '0;
        bus1.start = 1'b0; bus1.op_a = '0; bus1.op_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_state0", 32'(st0), 32'(ST_IDLE));
        chk("rst_outs0", {26'd0, bus0.ser_a, bus0.ser_b, bus0.ser_en,
                          bus0.par_load, bus0.busy, bus0.done}, 32'd0);
        chk("rst_result0", 32'(bus0.result), 32'd0);
        chk("rst_outs1", {26'd0, bus1.ser_a, bus1.ser_b, bus1.ser_en,
                          bus1.par_load, bus1.busy, bus1.done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed products at the default configuration.
        send0(8'h57, 8'h83);
        exp0_q[exp0_q.size()-1] = 16'h2B79;

        // Bit-level trace of the link for op_a=80, op_b=01.
        wait_idle0();
        bus0.start = 1'b1; bus0.op_a = 8'h80; bus0.op_b = 8'h01;
        exp0_q.push_back(16'h0080);
        exp0_cyc_q.push_back(cyc + 27);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) bus0.start = 1'b0;
            chk($sformatf("ser_a_T+%0d", k), 32'(bus0.ser_a), 32'(k == 1));
            chk($sformatf("ser_b_T+%0d", k), 32'(bus0.ser_b), 32'(k == 8));
            chk($sformatf("ser_en_T+%0d", k), 32'(bus0.ser_en), 32'(k == 9 || k == 10));
            chk($sformatf("par_load_T+%0d", k), 32'(bus0.par_load), 32'(k == 10));
        end

        send0(8'hFF, 8'hFF);
        exp0_q[exp0_q.size()-1] = 16'h5555;
        send0(8'h00, 8'h5A);
        exp0_q[exp0_q.size()-1] = 16'h0000;

        // start held high: one accept every 28 cycles, operands from accept cycle.
        wait_idle0();
        bus0.start = 1'b1; bus0.op_a = 8'h57; bus0.op_b = 8'h83;
        exp0_q.push_back(16'h2B79);
        exp0_cyc_q.push_back(cyc + 27);
        for (int k = 1; k <= 57; k++) begin
            @(negedge clk);
            if (k == 1) begin bus0.op_a = 8'hFF; bus0.op_b = 8'hFF; end
            if (k == 28) begin exp0_q.push_back(16'h5555); exp0_cyc_q.push_back(cyc + 27); end
            if (k == 29) begin bus0.op_a = 8'h0F; bus0.op_b = 8'h0F; end
            if (k == 56) begin exp0_q.push_back(16'h0055); exp0_cyc_q.push_back(cyc + 27); end
            if (k == 57) bus0.start = 1'b0;
        end

        // Reset mid-transaction: abort, clear result, no done afterwards.
        wait_idle0();
        bus0.start = 1'b1; bus0.op_a = 8'h12; bus0.op_b = 8'h34;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 1) bus0.start = 1'b0;
            if (k == 12) reset = 1'b1;
        end
        chk("abort_state", 32'(st0), 32'(ST_IDLE));
        chk("abort_outs", {26'd0, bus0.ser_a, bus0.ser_b, bus0.ser_en,
                           bus0.par_load, bus0.busy, bus0.done}, 32'd0);
        chk("abort_result", 32'(bus0.result), 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 200; i++) begin
            send0(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        // Narrow configuration: DATA_WIDTH=4, COMPUTE_CYCLES=1.
        send1(4'hF, 4'hF);
        exp1_q[exp1_q.size()-1] = 8'h55;
        send1(4'h9, 4'h3);
        exp1_q[exp1_q.size()-1] = 8'h1B;
        send1(4'h0, 4'h7);
        exp1_q[exp1_q.size()-1] = 8'h00;
        for (int i = 0; i < 200; i++) begin
            send1(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        begin
            int n = 0;
            while ((exp0_q.size() != 0 || exp1_q.size() != 0) && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("pending0", 32'(exp0_q.size()), 32'd0);
        chk("pending1", 32'(exp1_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
